// File: rtl/wwd_result_checker.sv
// wwd_result_checker: scores cpu WWD outputs against a loadable (inst count, expected value) table
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   tbl_we/addr/inst/ans    table write port, honoured in IDLE only
//   tbl_count               number of valid entries, sampled on start
//   start                   IDLE->RUN, DONE->IDLE
//   num_inst, output_port   cpu retired-instruction count and WWD port
//   is_halted               cpu halted flag
//   busy, done, all_pass    run state and verdict
//   pass/fail/miss_count    entry tallies (miss valid in DONE only)
//   cycle_count             RUN cycles elapsed, saturating at MAX_CYCLES
//   end_cause               0 none, 1 halt, 2 timeout, 3 fail
//   fail_valid/index/got/exp  first-failure record
// Optional: define WWD_CHECKER_STATUS_EN for a per-entry status array read via stat_addr/stat_data.
module wwd_result_checker #(
   parameter int WORD_SIZE    = 16,
   parameter int NUM_TEST     = 56,
   parameter int IDX_W        = 6,
   parameter int MAX_CYCLES   = 10000,
   parameter int STOP_ON_FAIL = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tbl_we,
   input  logic [IDX_W-1:0]     tbl_addr,
   input  logic [WORD_SIZE-1:0] tbl_inst,
   input  logic [WORD_SIZE-1:0] tbl_ans,
   input  logic [IDX_W:0]       tbl_count,
   input  logic                 start,
   input  logic [WORD_SIZE-1:0] num_inst,
   input  logic [WORD_SIZE-1:0] output_port,
   input  logic                 is_halted,
   output logic                 busy,
   output logic                 done,
   output logic                 all_pass,
   output logic [IDX_W:0]       pass_count,
   output logic [IDX_W:0]       fail_count,
   output logic [IDX_W:0]       miss_count,
   output logic [WORD_SIZE-1:0] cycle_count,
   output logic [1:0]           end_cause,
   output logic                 fail_valid,
   output logic [IDX_W-1:0]     fail_index,
   output logic [WORD_SIZE-1:0] fail_got,
   output logic [WORD_SIZE-1:0] fail_exp
`ifdef WWD_CHECKER_STATUS_EN
   ,
   input  logic [IDX_W-1:0]     stat_addr,
   output logic [1:0]           stat_data
`endif
);
   localparam logic [IDX_W:0]       NT   = (IDX_W+1)'(NUM_TEST);
   localparam logic [WORD_SIZE-1:0] MAXC = WORD_SIZE'(MAX_CYCLES);
   localparam logic [WORD_SIZE-1:0] LAST = WORD_SIZE'(MAX_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [WORD_SIZE-1:0] mem_inst [NUM_TEST];
   logic [WORD_SIZE-1:0] mem_ans  [NUM_TEST];
   logic [IDX_W:0]       count, ptr;
   logic [IDX_W-1:0]     ptr_i;
   logic [WORD_SIZE-1:0] cur_inst, cur_ans;
   logic                 eval, hit, skip, pass, mis;
   logic [1:0]           cause_nxt;

   // ptr < count <= NUM_TEST whenever eval is set, so the truncated index is in range
   always_comb begin
      ptr_i      = ptr[IDX_W-1:0];
      cur_inst   = mem_inst[ptr_i];
      cur_ans    = mem_ans[ptr_i];
      eval       = state == RUN && ptr < count;
      hit        = eval && num_inst == cur_inst;
      skip       = eval && num_inst > cur_inst;
      pass       = hit && output_port == cur_ans;
      mis        = hit && !pass;
      cause_nxt  = (mis && STOP_ON_FAIL != 0) ? 2'd3 : is_halted ? 2'd1 : (cycle_count == LAST) ? 2'd2 : 2'd0;
      state_nxt  = (state == IDLE && start) ? RUN :
                   (state == RUN && cause_nxt != 2'd0) ? DONE :
                   (state == DONE && start) ? IDLE : state;
      busy       = state == RUN;
      done       = state == DONE;
      miss_count = done ? count - pass_count - fail_count : '0;
      all_pass   = done && pass_count == count && fail_count == '0;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // table survives reset on purpose so a program can be rerun without reloading
   always_ff @(posedge clk) begin
      if (state == IDLE && tbl_we && {1'b0, tbl_addr} < NT) begin
         mem_inst[tbl_addr] <= tbl_inst;
         mem_ans[tbl_addr]  <= tbl_ans;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || (start && state != RUN)) begin
         count       <= (!reset && state == IDLE) ? ((tbl_count > NT) ? NT : tbl_count) : '0;
         ptr         <= '0;
         pass_count  <= '0;
         fail_count  <= '0;
         cycle_count <= '0;
         end_cause   <= 2'd0;
         fail_valid  <= 1'b0;
         fail_index  <= '0;
         fail_got    <= '0;
         fail_exp    <= '0;
      end else if (state == RUN) begin
         if (hit || skip) ptr <= ptr + 1'b1;
         if (pass) pass_count <= pass_count + 1'b1;
         if (mis) fail_count <= fail_count + 1'b1;
         if (mis && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_index <= ptr_i;
            fail_got   <= output_port;
            fail_exp   <= cur_ans;
         end
         if (cycle_count != MAXC) cycle_count <= cycle_count + 1'b1;
         if (cause_nxt != 2'd0) end_cause <= cause_nxt;
      end
   end

`ifdef WWD_CHECKER_STATUS_EN
   logic [1:0] stat [NUM_TEST];

   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         for (int i = 0; i < NUM_TEST; i++) stat[i] <= 2'd0;
      end else if (hit) begin
         stat[ptr_i] <= pass ? 2'd1 : 2'd2;
      end else if (skip) begin
         stat[ptr_i] <= 2'd3;
      end
   end

   always_comb stat_data = ({1'b0, stat_addr} < NT) ? stat[stat_addr] : 2'd0;
`endif
endmodule

// File: tb/tb_wwd_result_checker.sv
// tb_wwd_result_checker: directed and randomized runs of wwd_result_checker against a run-level reference model
module tb_wwd_result_checker;
   localparam int W  = 16;
   localparam int N  = 56;
   localparam int IW = 6;
   localparam int MC = 20;

   logic          clk = 1'b0, reset = 1'b1, tbl_we = 1'b0, start = 1'b0, is_halted = 1'b0;
   logic [IW-1:0] tbl_addr = '0;
   logic [W-1:0]  tbl_inst = '0, tbl_ans = '0, num_inst = '0, output_port = '0;
   logic [IW:0]   tbl_count = '0;
   logic          busy, done, all_pass, fail_valid;
   logic [IW:0]   pass_count, fail_count, miss_count;
   logic [W-1:0]  cycle_count, fail_got, fail_exp;
   logic [1:0]    end_cause;
   logic [IW-1:0] fail_index;
`ifdef WWD_CHECKER_STATUS_EN
   logic [IW-1:0] stat_addr = '0;
   logic [1:0]    stat_data;
`endif

   int tests = 0, fails = 0;
   int q_inst[$], q_ans[$], s_ni[$], s_op[$], s_h[$];

   wwd_result_checker #(.WORD_SIZE(W), .NUM_TEST(N), .IDX_W(IW), .MAX_CYCLES(MC), .STOP_ON_FAIL(1)) dut (
      .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_inst(tbl_inst),
      .tbl_ans(tbl_ans), .tbl_count(tbl_count), .start(start), .num_inst(num_inst),
      .output_port(output_port), .is_halted(is_halted), .busy(busy), .done(done),
      .all_pass(all_pass), .pass_count(pass_count), .fail_count(fail_count),
      .miss_count(miss_count), .cycle_count(cycle_count), .end_cause(end_cause),
      .fail_valid(fail_valid), .fail_index(fail_index), .fail_got(fail_got), .fail_exp(fail_exp)
`ifdef WWD_CHECKER_STATUS_EN
      , .stat_addr(stat_addr), .stat_data(stat_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load;
      for (int i = 0; i < q_inst.size(); i++) begin
         tbl_we   = 1'b1;
         tbl_addr = IW'(i);
         tbl_inst = W'(q_inst[i]);
         tbl_ans  = W'(q_ans[i]);
         tick();
      end
      tbl_we = 1'b0;
   endtask

   // Model: walk the stimulus cycle by cycle, one table entry considered per cycle,
   // stop on first mismatch, halt or the cycle budget; then compare the run's outcome.
   task automatic run(input string tag);
      int ptr = 0, ep = 0, ef = 0, ec = 0, efv = 0, efi = 0, efg = 0, efe = 0, ecyc = 0;
      int n, l, k, mis, got_cyc = 0;
      n = q_inst.size();
      l = s_ni.size();
      for (int c = 0; ec == 0; c++) begin
         k   = (c < l) ? c : l - 1;
         mis = 0;
         if (ptr < n) begin
            if (s_ni[k] == q_inst[ptr]) begin
               if (s_op[k] == q_ans[ptr]) ep++;
               else begin
                  ef++;
                  mis = 1;
                  if (efv == 0) begin
                     efv = 1; efi = ptr; efg = s_op[k]; efe = q_ans[ptr];
                  end
               end
               ptr++;
            end else if (s_ni[k] > q_inst[ptr]) ptr++;
         end
         ec   = (mis != 0) ? 3 : (s_h[k] != 0) ? 1 : (c == MC - 1) ? 2 : 0;
         ecyc = c + 1;
      end
      tbl_count = (IW+1)'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      for (int c = 0; c < 100; c++) begin
         k           = (c < l) ? c : l - 1;
         num_inst    = W'(s_ni[k]);
         output_port = W'(s_op[k]);
         is_halted   = s_h[k] != 0;
         tick();
         got_cyc++;
         if (done) break;
      end
      chk({tag, ".cycles"}, got_cyc, ecyc);
      chk({tag, ".pass"}, {25'd0, pass_count}, ep);
      chk({tag, ".fail"}, {25'd0, fail_count}, ef);
      chk({tag, ".miss"}, {25'd0, miss_count}, n - ep - ef);
      chk({tag, ".cause"}, {30'd0, end_cause}, ec);
      chk({tag, ".cycle_count"}, {16'd0, cycle_count}, ecyc);
      chk({tag, ".all_pass"}, {31'd0, all_pass}, (ep == n && ef == 0) ? 1 : 0);
      chk({tag, ".fail_valid"}, {31'd0, fail_valid}, efv);
      if (efv != 0) begin
         chk({tag, ".fail_index"}, {26'd0, fail_index}, efi);
         chk({tag, ".fail_got"}, {16'd0, fail_got}, efg);
         chk({tag, ".fail_exp"}, {16'd0, fail_exp}, efe);
      end
      num_inst  = num_inst + 1'b1;
      is_halted = 1'b0;
      tick();
      tick();
      chk({tag, ".frozen_pass"}, {25'd0, pass_count}, ep);
      chk({tag, ".frozen_done"}, {31'd0, done}, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, ".idle_done"}, {31'd0, done}, 0);
      chk({tag, ".idle_busy"}, {31'd0, busy}, 0);
      chk({tag, ".idle_pass"}, {25'd0, pass_count}, 0);
      num_inst = '0;
   endtask

   task automatic stim_t1(input int bad_at7, input int halt_at);
      s_ni = {}; s_op = {}; s_h = {};
      for (int i = 0; i <= halt_at; i++) begin
         s_ni.push_back(i);
         s_op.push_back((i == 7) ? ((bad_at7 != 0) ? 2 : 1) : 0);
         s_h.push_back((i == halt_at) ? 1 : 0);
      end
   endtask

   initial begin
      int n, v, l, ni, op, j;
      tick();
      tick();
      reset = 1'b0;
      chk("reset.busy", {31'd0, busy}, 0);
      chk("reset.done", {31'd0, done}, 0);
      chk("reset.pass", {25'd0, pass_count}, 0);
      chk("reset.fail", {25'd0, fail_count}, 0);
      chk("reset.miss", {25'd0, miss_count}, 0);
      chk("reset.cycle", {16'd0, cycle_count}, 0);
      chk("reset.cause", {30'd0, end_cause}, 0);
      chk("reset.fail_valid", {31'd0, fail_valid}, 0);
      chk("reset.all_pass", {31'd0, all_pass}, 0);

      q_inst = '{3, 5, 7};
      q_ans  = '{0, 0, 1};
      load();
      stim_t1(0, 9);
      run("all_pass");
      stim_t1(1, 9);
      run("stop_on_fail");
      stim_t1(0, 7);
      run("halt_with_last");
      s_ni = '{0}; s_op = '{0}; s_h = '{0};
      run("timeout");

      tbl_count = 7'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         num_inst = W'(i);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset.busy", {31'd0, busy}, 0);
      chk("midreset.pass", {25'd0, pass_count}, 0);
      chk("midreset.cycle", {16'd0, cycle_count}, 0);
      stim_t1(0, 9);
      run("after_reset");

      q_inst = '{3, 5};
      q_ans  = '{0, 0};
      load();
      s_ni = '{0, 1, 2, 6, 6, 6, 6};
      s_op = '{0, 0, 0, 0, 0, 0, 0};
      s_h  = '{0, 0, 0, 0, 0, 0, 1};
      run("skip");

      for (int r = 0; r < 25; r++) begin
         q_inst = {}; q_ans = {}; s_ni = {}; s_op = {}; s_h = {};
         n = $urandom_range(1, 6);
         v = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) begin
            q_inst.push_back(v);
            q_ans.push_back($urandom_range(0, 65535));
            v += $urandom_range(1, 3);
         end
         load();
         l  = $urandom_range(4, 22);
         ni = 0;
         for (int c = 0; c < l; c++) begin
            j = -1;
            for (int i = 0; i < n; i++) if (q_inst[i] == ni) j = i;
            if (j >= 0) op = ($urandom_range(0, 4) == 0) ? (q_ans[j] ^ 1) : q_ans[j];
            else op = $urandom_range(0, 65535);
            s_ni.push_back(ni);
            s_op.push_back(op);
            s_h.push_back((c == l - 1 && $urandom_range(0, 9) < 7) ? 1 : 0);
            ni += $urandom_range(0, 3);
         end
         run($sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
